conv_stream_engine: RTL
=======================

CONV_STREAM_ENGINE -- requirements
Module: conv_stream_engine

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH=8, unsigned pixel width; COEF_WIDTH=8, signed coefficient width; IMG_WIDTH=32, pixels per row (>=3); IMG_HEIGHT=32, rows per frame (>=3); ACC_WIDTH=32, signed accumulator width; OUT_WIDTH=8, post-processed pixel width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_weights  in  9*COEF_WIDTH  kernel; k[r][c] at bits (3r+c)*COEF_WIDTH, r0 = top (oldest) row, c0 = left (oldest) column.
- cfg_shift  in  5  arithmetic right shift applied before clamping.
- cfg_abs  in  1  1 = take magnitude before shift.
- cfg_same  in  1  0 = valid-only windows; 1 = one output per input, border outputs forced to 0.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  engine accepts the pixel this cycle.
- in_data  in  DATA_WIDTH  raster-order pixel.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- out_acc  out  ACC_WIDTH  raw signed window sum.
- out_pixel  out  OUT_WIDTH  post-processed pixel.
- out_sof  out  1  first output of frame.
- out_eol  out  1  last output of a row.
- frame_done  out  1  one-cycle pulse when the last output of a frame transfers.

Function
REQ-003 Transfer SHALL occur on in_valid & in_ready (input) and out_valid & out_ready (output); out_* SHALL hold stable while out_valid & !out_ready.
REQ-004 Pipeline SHALL advance when out_ready | !out_valid; in_ready SHALL equal this advance term (global stall, no combinational in_valid->in_ready path).
REQ-005 Column/row counters SHALL track each accepted pixel, wrap col at IMG_WIDTH-1 and row at IMG_HEIGHT-1; the pixel after the final one starts a new frame.
REQ-006 Frame FSM SHALL have states IDLE (no pixel of the current frame accepted) and ACTIVE; IDLE->ACTIVE on first accept, latching cfg_weights, cfg_shift, cfg_abs and cfg_same into shadow registers; ACTIVE->IDLE on accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1). Config changes mid-frame SHALL NOT affect that frame.
REQ-007 Two IMG_WIDTH-deep line buffers plus a 3x3 register window SHALL form the window whose bottom-right element is the pixel just accepted.
REQ-008 Valid-only mode: a window SHALL be emitted iff row>=2 and col>=2 at accept, giving (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame; same mode: every accepted pixel SHALL produce one output, with out_acc=0 and out_pixel=0 when row<2 or col<2.
REQ-009 Stages: S1 registers 9 products (pixel zero-extended, coefficient signed); S2 registers the sign-extended sum to ACC_WIDTH; S3 registers post-processing to the output. Latency SHALL be exactly 3 cycles from accept to out_valid when unstalled; throughput 1 pixel/cycle.
REQ-010 Post-processing: v = cfg_abs ? |acc| : acc; v >>>= cfg_shift; out_pixel = clamp(v, 0, 2^OUT_WIDTH-1).
REQ-011 The kernel SHALL be applied as correlation (no flip): sum k[r][c]*p[r][c].
REQ-012 out_sof SHALL mark the first emitted output of the frame; out_eol SHALL mark the output at the last emitted column of each row; frame_done SHALL pulse in the cycle the last output of the frame transfers.
REQ-013 No pixel SHALL be lost or duplicated under any out_ready pattern.

Reset
REQ-014 On rst_n low, immediately: out_valid=0, out_acc=0, out_pixel=0, out_sof=0, out_eol=0, frame_done=0, counters=0, FSM=IDLE, all pipeline valids=0; in_ready SHALL be 1 from the first clock edge after release.
REQ-015 Reset mid-frame SHALL discard the partial frame; line buffer contents need not be cleared, because row gating excludes stale data.

Structure
REQ-016 The shared package SHALL hold the FSM state encoding and the kernel-index helper constants (KSIZE=3, NTAPS=9).
REQ-017 One sub-module, conv_line_buffer (parametrised depth/width, enable-gated shift), SHALL be used; multiply, add and clamp SHALL stay inline.

Verification
REQ-018 Identity kernel (k11=1), 5x4 ramp p=10r+c, valid-only -> 6 outputs equal to interior pixels 11,12,13,21,22,23, out_sof on the first, out_eol on 13 and 23.
REQ-019 All-ones kernel, constant image 10, shift 0 -> out_acc=90, out_pixel=90; shift 2 -> out_pixel=22.
REQ-020 Laplacian (k11=8, others -1) across a 0->100 vertical edge -> negative acc clamps to out_pixel 0 with cfg_abs=0, magnitude 255 (clamped) with cfg_abs=1.
REQ-021 Random out_ready (50%), 32x32 random frame -> sequence identical to the unstalled run, in_ready low exactly while stalled, one frame_done.
REQ-022 Same mode 5x4 -> 20 outputs, row 0/1 and col 0/1 zero; weights changed mid-frame apply only from the next frame; rst_n pulse mid-frame -> out_valid 0 at once, next frame correct.

Source files
------------

// File: rtl/conv_stream_engine_pkg.sv
// Shared types and kernel geometry for the streaming 3x3 convolution engine.
package conv_stream_engine_pkg;

  localparam int KSIZE = 3;
  localparam int NTAPS = KSIZE * KSIZE;

  // Frame-level control state: IDLE until the first pixel of a frame lands.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_e;

  // Flat tap index of kernel element k[r][c] (row-major, r0 = oldest row).
  function automatic int tap_idx(input int r, input int c);
    return r * KSIZE + c;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Enable-gated shift-register line buffer: dout is the sample written DEPTH
// enables ago, i.e. the pixel one row above the incoming one.
module conv_line_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Shift one position per accepted pixel; contents only matter once rows fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (en) begin
      mem_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
      end
    end
  end

  assign dout = mem_r[DEPTH-1];

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming 3x3 correlation engine: raster pixels in, one window result per
// valid (or every, in same mode) position out, 3-stage pipeline, global stall.
module conv_stream_engine
  import conv_stream_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [9*COEF_WIDTH-1:0]   cfg_weights,
  input  logic [4:0]                cfg_shift,
  input  logic                      cfg_abs,
  input  logic                      cfg_same,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_acc,
  output logic [OUT_WIDTH-1:0]      out_pixel,
  output logic                      out_sof,
  output logic                      out_eol,
  output logic                      frame_done
);

  localparam int CW     = $clog2(IMG_WIDTH);
  localparam int RW     = $clog2(IMG_HEIGHT);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic signed [ACC_WIDTH-1:0] PIX_MAX =
    {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  // Handshake
  logic advance_s;
  logic accept_s;

  // Position and frame control
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  frame_state_e  state_r;
  frame_state_e  state_nxt_s;

  // Per-frame configuration
  logic [9*COEF_WIDTH-1:0] w_sh_r;
  logic [4:0]              shift_sh_r;
  logic                    abs_sh_r;
  logic                    same_sh_r;
  logic [9*COEF_WIDTH-1:0] w_eff_s;
  logic [4:0]              shift_eff_s;
  logic                    abs_eff_s;
  logic                    same_eff_s;

  // Window
  logic [DATA_WIDTH-1:0] lb0_dout_s;
  logic [DATA_WIDTH-1:0] lb1_dout_s;
  logic [DATA_WIDTH-1:0] win_r     [KSIZE][KSIZE];
  logic [DATA_WIDTH-1:0] win_nxt_s [KSIZE][KSIZE];
  logic interior_s, emit_s, sof_s, eol_s, last_s;

  // S1: products
  logic signed [PROD_W-1:0] prod_s    [NTAPS];
  logic signed [PROD_W-1:0] s1_prod_r [NTAPS];
  logic       s1_valid_r, s1_sof_r, s1_eol_r, s1_last_r, s1_abs_r;
  logic [4:0] s1_shift_r;

  // S2: sum
  logic signed [ACC_WIDTH-1:0] sum_s;
  logic signed [ACC_WIDTH-1:0] s2_acc_r;
  logic       s2_valid_r, s2_sof_r, s2_eol_r, s2_last_r, s2_abs_r;
  logic [4:0] s2_shift_r;

  // S3: post-processing and output registers
  logic signed [ACC_WIDTH-1:0] abs_v_s;
  logic signed [ACC_WIDTH-1:0] shr_s;
  logic [OUT_WIDTH-1:0]        pix_s;
  logic                        out_valid_r, out_sof_r, out_eol_r, out_last_r;
  logic [ACC_WIDTH-1:0]        out_acc_r;
  logic [OUT_WIDTH-1:0]        out_pixel_r;

  // Whole pipeline moves together; input readiness never depends on in_valid.
  assign advance_s = out_ready | ~out_valid_r;
  assign accept_s  = in_valid & advance_s;
  assign in_ready  = advance_s;

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= '0;
      row_r <= '0;
    end else if (accept_s) begin
      if (col_r == COL_LAST) begin
        col_r <= '0;
        if (row_r == ROW_LAST) begin
          row_r <= '0;
        end else begin
          row_r <= row_r + RW'(1);
        end
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame state transitions: first accept opens a frame, last pixel closes it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (accept_s && last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Freeze configuration at the first pixel so mid-frame changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_sh_r     <= '0;
      shift_sh_r <= 5'd0;
      abs_sh_r   <= 1'b0;
      same_sh_r  <= 1'b0;
    end else if ((state_r == ST_IDLE) && accept_s) begin
      w_sh_r     <= cfg_weights;
      shift_sh_r <= cfg_shift;
      abs_sh_r   <= cfg_abs;
      same_sh_r  <= cfg_same;
    end
  end

  // The first pixel of a frame is processed before the shadow copy exists.
  always_comb begin
    if (state_r == ST_IDLE) begin
      w_eff_s     = cfg_weights;
      shift_eff_s = cfg_shift;
      abs_eff_s   = cfg_abs;
      same_eff_s  = cfg_same;
    end else begin
      w_eff_s     = w_sh_r;
      shift_eff_s = shift_sh_r;
      abs_eff_s   = abs_sh_r;
      same_eff_s  = same_sh_r;
    end
  end

  conv_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb0 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept_s),
    .din  (in_data),
    .dout (lb0_dout_s)
  );

  conv_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept_s),
    .din  (lb0_dout_s),
    .dout (lb1_dout_s)
  );

  // Window after this accept: shift left, new column = {row-2, row-1, current}.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) begin
        win_nxt_s[r][c] = win_r[r][c+1];
      end
    end
    win_nxt_s[0][KSIZE-1] = lb1_dout_s;
    win_nxt_s[1][KSIZE-1] = lb0_dout_s;
    win_nxt_s[2][KSIZE-1] = in_data;
  end

  // Window register, updated only on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          win_r[r][c] <= '0;
        end
      end
    end else if (accept_s) begin
      win_r <= win_nxt_s;
    end
  end

  // Emission decision and stream markers for the pixel being accepted.
  always_comb begin
    interior_s = (row_r >= ROW_TWO) && (col_r >= COL_TWO);
    emit_s     = same_eff_s | interior_s;
    if (same_eff_s) begin
      sof_s = (row_r == '0) && (col_r == '0);
    end else begin
      sof_s = (row_r == ROW_TWO) && (col_r == COL_TWO);
    end
    eol_s  = (col_r == COL_LAST);
    last_s = eol_s && (row_r == ROW_LAST);
  end

  // Tap products; border windows contribute nothing so same-mode edges read 0.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        if (interior_s) begin
          prod_s[tap_idx(r, c)] = PROD_W'($signed({1'b0, win_nxt_s[r][c]})) *
            PROD_W'($signed(w_eff_s[tap_idx(r, c)*COEF_WIDTH +: COEF_WIDTH]));
        end else begin
          prod_s[tap_idx(r, c)] = '0;
        end
      end
    end
  end

  // S1: register products plus the post-processing settings that travel along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        s1_prod_r[i] <= '0;
      end
      s1_valid_r <= 1'b0;
      s1_sof_r   <= 1'b0;
      s1_eol_r   <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_abs_r   <= 1'b0;
      s1_shift_r <= 5'd0;
    end else if (advance_s) begin
      s1_prod_r  <= prod_s;
      s1_valid_r <= accept_s & emit_s;
      s1_sof_r   <= accept_s & emit_s & sof_s;
      s1_eol_r   <= accept_s & emit_s & eol_s;
      s1_last_r  <= accept_s & emit_s & last_s;
      s1_abs_r   <= abs_eff_s;
      s1_shift_r <= shift_eff_s;
    end
  end

  // Sum of the nine sign-extended products.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < NTAPS; i++) begin
      sum_s = sum_s + ACC_WIDTH'(s1_prod_r[i]);
    end
  end

  // S2: register the window sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_acc_r   <= '0;
      s2_valid_r <= 1'b0;
      s2_sof_r   <= 1'b0;
      s2_eol_r   <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_abs_r   <= 1'b0;
      s2_shift_r <= 5'd0;
    end else if (advance_s) begin
      s2_acc_r   <= sum_s;
      s2_valid_r <= s1_valid_r;
      s2_sof_r   <= s1_sof_r;
      s2_eol_r   <= s1_eol_r;
      s2_last_r  <= s1_last_r;
      s2_abs_r   <= s1_abs_r;
      s2_shift_r <= s1_shift_r;
    end
  end

  // Magnitude, arithmetic shift, then clamp into the output pixel range.
  always_comb begin
    if (s2_abs_r && s2_acc_r[ACC_WIDTH-1]) begin
      abs_v_s = -s2_acc_r;
    end else begin
      abs_v_s = s2_acc_r;
    end
    shr_s = abs_v_s >>> s2_shift_r;
    if (shr_s[ACC_WIDTH-1]) begin
      pix_s = '0;
    end else if (shr_s > PIX_MAX) begin
      pix_s = '1;
    end else begin
      pix_s = shr_s[OUT_WIDTH-1:0];
    end
  end

  // S3: output registers, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_acc_r   <= '0;
      out_pixel_r <= '0;
      out_sof_r   <= 1'b0;
      out_eol_r   <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (advance_s) begin
      out_valid_r <= s2_valid_r;
      out_acc_r   <= s2_acc_r;
      out_pixel_r <= pix_s;
      out_sof_r   <= s2_sof_r;
      out_eol_r   <= s2_eol_r;
      out_last_r  <= s2_last_r;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_acc    = out_acc_r;
  assign out_pixel  = out_pixel_r;
  assign out_sof    = out_sof_r;
  assign out_eol    = out_eol_r;
  assign frame_done = out_valid_r & out_ready & out_last_r;

endmodule
